segment_transition_ctl: RTL and testbench
=========================================

// Module: segment_transition_ctl
// PURPOSE
//  Sequences the double-buffered (2-segment) modulation or STM datapath: decides when the read side swaps
//  from the running segment to a newly requested one, and counts loop repetitions to stop or auto-toggle.
//  One instance serves modulation and one serves STM; sits between the controller register file and the
//  segment timer/index generator. Implements transition modes SYNC_IDX, SYS_TIME, GPIO and EXT.
// PARAMETERS
//  REP_WIDTH   16  width of repetition count; all-ones = infinite
//  TIME_WIDTH  64  width of system time and transition value
//  GPIO_WIDTH  4   number of GPIO trigger inputs
// PORTS
//  CLK                 in   1           system clock; sole clock domain
//  RESET_N             in   1           asynchronous, active-low reset
//  UPDATE_SETTINGS     in   1           1-cycle strobe: latch REQ_* inputs as a new request
//  REQ_RD_SEGMENT      in   1           requested segment
//  REQ_REP             in   REP_WIDTH   loops to play minus 1; all-ones = infinite
//  REQ_MODE            in   8           0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO, 0xF0 EXT
//  REQ_VALUE           in   TIME_WIDTH  SYS_TIME: target time; GPIO: [1:0] selects pin; else ignored
//  SYS_TIME            in   TIME_WIDTH  free-running system time, monotonic
//  GPIO_IN             in   GPIO_WIDTH  already-synchronised GPIO levels
//  IDX_WRAP            in   1           1-cycle strobe: running segment index wrapped cycle-1 -> 0
//  SEGMENT             out  1           segment currently read by the datapath
//  STOP                out  1           repetitions exhausted; datapath holds last sample
//  SWAP                out  1           1-cycle strobe on every SEGMENT change; timer restarts index at 0
//  PENDING             out  1           a request is waiting for its trigger
// BEHAVIOUR
//  Reset: SEGMENT=0, STOP=0, SWAP=0, PENDING=0, state RUN, active rep = all-ones, mode SYNC_IDX, loop_cnt=0.
//  States: RUN (no request pending), WAIT (request latched, waiting for trigger).
//  UPDATE_SETTINGS in any state: latch segment/rep/mode/value into pending regs.
//   - REQ_RD_SEGMENT == SEGMENT and mode != EXT: no swap; active rep <- REQ_REP, loop_cnt <- 0, STOP <- 0,
//     state RUN, next cycle. PENDING stays 0.
//   - otherwise: state WAIT, PENDING=1 next cycle. A new strobe in WAIT replaces the pending request.
//  Triggers evaluated in WAIT only, from registered inputs:
//   - SYNC_IDX: IDX_WRAP=1, or STOP=1 (stopped segment swaps on next cycle).
//   - SYS_TIME: SYS_TIME >= value (unsigned); past target fires on first WAIT cycle.
//   - GPIO: rising edge of GPIO_IN[value[1:0]] (prev-sample 0, now 1); level already high does not fire.
//   - EXT: fires on first WAIT cycle.
//   - any other mode code: treated as SYNC_IDX.
//  On trigger (cycle T): at T+1 SEGMENT <- pending segment, SWAP=1 for one cycle, STOP=0, loop_cnt=0,
//   active rep/mode <- pending, PENDING=0, state RUN.
//  UPDATE_SETTINGS coincident with a trigger: strobe wins; trigger discarded, new request evaluated.
//  Loop counting in RUN: each IDX_WRAP increments loop_cnt (saturating REP_WIDTH). When active rep != all-ones
//   and the wrap makes loop_cnt == rep+1:
//   - mode EXT: toggle SEGMENT, SWAP=1, loop_cnt=0 at next cycle (continuous alternation, same rep).
//   - else: STOP=1 and held until next swap or same-segment update. IDX_WRAP ignored while STOP=1.
//  Infinite rep: loop_cnt never stops the segment; no wrap-around effect.
//  IDX_WRAP in the cycle of SWAP output: ignored (belongs to old segment).
//  Reset mid-WAIT discards the request; outputs return to reset values asynchronously.
// TESTING
//  SEG=0 running, request seg1 SYNC_IDX rep=1; IDX_WRAP at cycle 10 -> SWAP@11, SEGMENT=1; 2 more wraps -> STOP=1.
//  SYS_TIME mode value=1000, SYS_TIME counting from 990 -> SWAP exactly one cycle after SYS_TIME==1000; value=5 -> swap next cycle.
//  GPIO mode value=2 with GPIO_IN[2] already high -> no swap; drop then raise -> SWAP one cycle after the rising edge.
//  EXT mode rep=0, seg1 requested -> immediate swap, then SEGMENT toggles on every IDX_WRAP, never STOP.
//  Same-segment update rep=0xFFFF while STOP=1 -> STOP=0, no SWAP; update coincident with IDX_WRAP trigger -> no swap that cycle.
//  Assert RESET_N low while PENDING=1 -> SEGMENT=0, PENDING=0 immediately; no SWAP after release.

Source files
------------

// File: rtl/segment_transition_ctl.sv
// Segment swap sequencer for the double-buffered modulation / STM read path.
// Latches segment requests, waits for the selected trigger, and counts loop repetitions.
module segment_transition_ctl #(
    parameter int REP_WIDTH  = 16,
    parameter int TIME_WIDTH = 64,
    parameter int GPIO_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  UPDATE_SETTINGS,
    input  logic                  REQ_RD_SEGMENT,
    input  logic [REP_WIDTH-1:0]  REQ_REP,
    input  logic [7:0]            REQ_MODE,
    input  logic [TIME_WIDTH-1:0] REQ_VALUE,
    input  logic [TIME_WIDTH-1:0] SYS_TIME,
    input  logic [GPIO_WIDTH-1:0] GPIO_IN,
    input  logic                  IDX_WRAP,
    output logic                  SEGMENT,
    output logic                  STOP,
    output logic                  SWAP,
    output logic                  PENDING
);

    typedef enum logic {
        ST_RUN,
        ST_WAIT
    } state_t;

    typedef enum logic [1:0] {
        M_SYNC_IDX,
        M_SYS_TIME,
        M_GPIO,
        M_EXT
    } mode_t;

    localparam logic [REP_WIDTH-1:0] REP_INF = '1;
    localparam logic [REP_WIDTH-1:0] REP_ONE = {{(REP_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state, state_n;
    logic                    seg_q, seg_n;
    logic                    stop_q, stop_n;
    logic                    swap_q, swap_n;
    logic [REP_WIDTH-1:0]    act_rep, act_rep_n;
    mode_t                   act_mode, act_mode_n;
    logic [REP_WIDTH-1:0]    loop_cnt, loop_n;

    logic                    pend_seg;
    logic [REP_WIDTH-1:0]    pend_rep;
    mode_t                   pend_mode;
    logic [TIME_WIDTH-1:0]   pend_value;

    logic [3:0]              gpio_now;
    logic [3:0]              gpio_prev;
    mode_t                   req_mode_dec;
    logic                    trig;
    logic [REP_WIDTH-1:0]    cnt_inc;

    generate
        if (GPIO_WIDTH >= 4) begin : g_gpio_wide
            assign gpio_now = GPIO_IN[3:0];
        end else begin : g_gpio_narrow
            assign gpio_now = {{(4-GPIO_WIDTH){1'b0}}, GPIO_IN};
        end
    endgenerate

    // Unknown mode codes fall back to index-synchronous swapping.
    always_comb begin
        case (REQ_MODE)
            8'h01:   req_mode_dec = M_SYS_TIME;
            8'h02:   req_mode_dec = M_GPIO;
            8'hF0:   req_mode_dec = M_EXT;
            default: req_mode_dec = M_SYNC_IDX;
        endcase
    end

    always_comb begin
        trig = 1'b0;
        case (pend_mode)
            M_SYNC_IDX: trig = IDX_WRAP | stop_q;
            M_SYS_TIME: trig = (SYS_TIME >= pend_value);
            M_GPIO:     trig = gpio_now[pend_value[1:0]] & ~gpio_prev[pend_value[1:0]];
            M_EXT:      trig = 1'b1;
            default:    trig = 1'b0;
        endcase
    end

    assign cnt_inc = (loop_cnt == REP_INF) ? loop_cnt : loop_cnt + REP_ONE;

    always_comb begin
        state_n    = state;
        seg_n      = seg_q;
        stop_n     = stop_q;
        swap_n     = 1'b0;
        act_rep_n  = act_rep;
        act_mode_n = act_mode;
        loop_n     = loop_cnt;

        if (UPDATE_SETTINGS) begin
            // A strobe overrides any trigger or loop event in the same cycle.
            if ((REQ_RD_SEGMENT == seg_q) && (req_mode_dec != M_EXT)) begin
                state_n   = ST_RUN;
                act_rep_n = REQ_REP;
                loop_n    = '0;
                stop_n    = 1'b0;
            end else begin
                state_n = ST_WAIT;
            end
        end else if (state == ST_WAIT) begin
            if (trig) begin
                state_n    = ST_RUN;
                seg_n      = pend_seg;
                swap_n     = 1'b1;
                stop_n     = 1'b0;
                loop_n     = '0;
                act_rep_n  = pend_rep;
                act_mode_n = pend_mode;
            end
        end else begin
            // A wrap seen alongside SWAP belongs to the segment just left.
            if (IDX_WRAP && !stop_q && !swap_q) begin
                loop_n = cnt_inc;
                if ((act_rep != REP_INF) && (cnt_inc == act_rep + REP_ONE)) begin
                    if (act_mode == M_EXT) begin
                        seg_n  = ~seg_q;
                        swap_n = 1'b1;
                        loop_n = '0;
                    end else begin
                        stop_n = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_RUN;
            seg_q     <= 1'b0;
            stop_q    <= 1'b0;
            swap_q    <= 1'b0;
            act_rep   <= REP_INF;
            act_mode  <= M_SYNC_IDX;
            loop_cnt  <= '0;
            gpio_prev <= '0;
        end else begin
            state     <= state_n;
            seg_q     <= seg_n;
            stop_q    <= stop_n;
            swap_q    <= swap_n;
            act_rep   <= act_rep_n;
            act_mode  <= act_mode_n;
            loop_cnt  <= loop_n;
            gpio_prev <= gpio_now;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pend_seg   <= 1'b0;
            pend_rep   <= '0;
            pend_mode  <= M_SYNC_IDX;
            pend_value <= '0;
        end else if (UPDATE_SETTINGS) begin
            pend_seg   <= REQ_RD_SEGMENT;
            pend_rep   <= REQ_REP;
            pend_mode  <= req_mode_dec;
            pend_value <= REQ_VALUE;
        end
    end

    assign SEGMENT = seg_q;
    assign STOP    = stop_q;
    assign SWAP    = swap_q;
    assign PENDING = (state == ST_WAIT);

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Directed vector bench for segment_transition_ctl: one record per clock cycle,
// expected {SEGMENT,STOP,SWAP,PENDING} after that cycle's edge, plus a reset sequence.
module tb_segment_transition_ctl;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        UPDATE_SETTINGS = 1'b0;
    logic        REQ_RD_SEGMENT = 1'b0;
    logic [15:0] REQ_REP = '0;
    logic [7:0]  REQ_MODE = '0;
    logic [63:0] REQ_VALUE = '0;
    logic [63:0] SYS_TIME = '0;
    logic [3:0]  GPIO_IN = '0;
    logic        IDX_WRAP = 1'b0;
    logic        SEGMENT, STOP, SWAP, PENDING;

    int total = 0;
    int bad = 0;

    segment_transition_ctl #(
        .REP_WIDTH (16),
        .TIME_WIDTH(64),
        .GPIO_WIDTH(4)
    ) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .UPDATE_SETTINGS(UPDATE_SETTINGS),
        .REQ_RD_SEGMENT (REQ_RD_SEGMENT),
        .REQ_REP        (REQ_REP),
        .REQ_MODE       (REQ_MODE),
        .REQ_VALUE      (REQ_VALUE),
        .SYS_TIME       (SYS_TIME),
        .GPIO_IN        (GPIO_IN),
        .IDX_WRAP       (IDX_WRAP),
        .SEGMENT        (SEGMENT),
        .STOP           (STOP),
        .SWAP           (SWAP),
        .PENDING        (PENDING)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        upd;
        logic        seg;
        logic [15:0] rep;
        logic [7:0]  mode;
        logic [63:0] value;
        logic [63:0] sys;
        logic [3:0]  gpio;
        logic        wrap;
        logic [3:0]  exp;   // {SEGMENT, STOP, SWAP, PENDING}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic upd, input logic seg, input logic [15:0] rep,
                                input logic [7:0] mode, input logic [63:0] value,
                                input logic [63:0] sys, input logic [3:0] gpio,
                                input logic wrap, input logic [3:0] exp);
        vec_t v;
        v.upd = upd; v.seg = seg; v.rep = rep; v.mode = mode; v.value = value;
        v.sys = sys; v.gpio = gpio; v.wrap = wrap; v.exp = exp;
        return v;
    endfunction

    function automatic vec_t cyc(input logic wrap, input logic [3:0] exp);
        return mk(1'b0, 1'b0, 16'h0, 8'h0, 64'd0, 64'd0, 4'b0, wrap, exp);
    endfunction

    task automatic check(input string name, input logic [3:0] want);
        logic [3:0] got;
        got = {SEGMENT, STOP, SWAP, PENDING};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s {seg,stop,swap,pend} got=%b want=%b", name, got, want);
        end
    endtask

    initial begin
        // SYNC_IDX request rep=1, swap on wrap, then stop after two loops
        vecs.push_back(cyc(0, 4'b0000));
        vecs.push_back(mk(1, 1, 16'd1, 8'h00, 64'd0, 64'd0, 4'b0, 0, 4'b0001));
        vecs.push_back(cyc(0, 4'b0001));
        vecs.push_back(cyc(1, 4'b1010));
        vecs.push_back(cyc(1, 4'b1000));   // wrap during SWAP ignored
        vecs.push_back(cyc(1, 4'b1000));
        vecs.push_back(cyc(1, 4'b1100));
        vecs.push_back(cyc(1, 4'b1100));
        // same-segment update clears STOP, infinite rep never stops
        vecs.push_back(mk(1, 1, 16'hFFFF, 8'h00, 64'd0, 64'd0, 4'b0, 0, 4'b1000));
        vecs.push_back(cyc(1, 4'b1000));
        vecs.push_back(cyc(1, 4'b1000));
        // rep=0 stops after one wrap; stopped segment swaps on the next cycle
        vecs.push_back(mk(1, 1, 16'd0, 8'h00, 64'd0, 64'd0, 4'b0, 0, 4'b1000));
        vecs.push_back(cyc(1, 4'b1100));
        vecs.push_back(mk(1, 0, 16'hFFFF, 8'h00, 64'd0, 64'd0, 4'b0, 0, 4'b1101));
        vecs.push_back(cyc(0, 4'b0010));
        vecs.push_back(cyc(0, 4'b0000));
        // update coincident with a wrap trigger: no swap that cycle
        vecs.push_back(mk(1, 1, 16'hFFFF, 8'h00, 64'd0, 64'd0, 4'b0, 0, 4'b0001));
        vecs.push_back(mk(1, 1, 16'hFFFF, 8'h00, 64'd0, 64'd0, 4'b0, 1, 4'b0001));
        vecs.push_back(cyc(1, 4'b1010));
        vecs.push_back(cyc(0, 4'b1000));
        // SYS_TIME target 1000
        vecs.push_back(mk(1, 0, 16'hFFFF, 8'h01, 64'd1000, 64'd990, 4'b0, 0, 4'b1001));
        vecs.push_back(mk(0, 0, 16'h0, 8'h0, 64'd0, 64'd998, 4'b0, 0, 4'b1001));
        vecs.push_back(mk(0, 0, 16'h0, 8'h0, 64'd0, 64'd999, 4'b0, 0, 4'b1001));
        vecs.push_back(mk(0, 0, 16'h0, 8'h0, 64'd0, 64'd1000, 4'b0, 0, 4'b0010));
        vecs.push_back(mk(0, 0, 16'h0, 8'h0, 64'd0, 64'd1001, 4'b0, 0, 4'b0000));
        // SYS_TIME target already in the past
        vecs.push_back(mk(1, 1, 16'hFFFF, 8'h01, 64'd5, 64'd1002, 4'b0, 0, 4'b0001));
        vecs.push_back(mk(0, 0, 16'h0, 8'h0, 64'd0, 64'd1003, 4'b0, 0, 4'b1010));
        vecs.push_back(cyc(0, 4'b1000));
        // GPIO pin 2: high level ignored, other pin ignored, rising edge fires
        vecs.push_back(mk(1, 0, 16'hFFFF, 8'h02, 64'd2, 64'd0, 4'b0100, 0, 4'b1001));
        vecs.push_back(mk(0, 0, 16'h0, 8'h0, 64'd0, 64'd0, 4'b0100, 0, 4'b1001));
        vecs.push_back(mk(0, 0, 16'h0, 8'h0, 64'd0, 64'd0, 4'b0000, 0, 4'b1001));
        vecs.push_back(mk(0, 0, 16'h0, 8'h0, 64'd0, 64'd0, 4'b0010, 0, 4'b1001));
        vecs.push_back(mk(0, 0, 16'h0, 8'h0, 64'd0, 64'd0, 4'b0100, 0, 4'b0010));
        vecs.push_back(mk(0, 0, 16'h0, 8'h0, 64'd0, 64'd0, 4'b0100, 0, 4'b0000));
        // EXT rep=0: immediate swap then toggle on every wrap, never STOP
        vecs.push_back(mk(1, 1, 16'd0, 8'hF0, 64'd0, 64'd0, 4'b0, 0, 4'b0001));
        vecs.push_back(cyc(0, 4'b1010));
        vecs.push_back(cyc(0, 4'b1000));
        vecs.push_back(cyc(1, 4'b0010));
        vecs.push_back(cyc(1, 4'b0000));
        vecs.push_back(cyc(1, 4'b1010));
        vecs.push_back(cyc(0, 4'b1000));
        vecs.push_back(cyc(1, 4'b0010));
        vecs.push_back(cyc(0, 4'b0000));
        vecs.push_back(cyc(1, 4'b1010));
        // leave a far-future SYS_TIME request pending for the reset sequence
        vecs.push_back(mk(1, 0, 16'hFFFF, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'b0, 0, 4'b1001));
        vecs.push_back(cyc(1, 4'b1001));

        #12;
        check("reset_state", 4'b0000);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        check("after_release", 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            UPDATE_SETTINGS = vecs[i].upd;
            REQ_RD_SEGMENT  = vecs[i].seg;
            REQ_REP         = vecs[i].rep;
            REQ_MODE        = vecs[i].mode;
            REQ_VALUE       = vecs[i].value;
            SYS_TIME        = vecs[i].sys;
            GPIO_IN         = vecs[i].gpio;
            IDX_WRAP        = vecs[i].wrap;
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // asynchronous reset while a request is pending and SEGMENT=1
        #2;
        RESET_N = 1'b0;
        #1;
        check("async_reset_mid_wait", 4'b0000);
        @(negedge CLK);
        UPDATE_SETTINGS = 1'b0;
        IDX_WRAP        = 1'b1;
        SYS_TIME        = 64'hFFFF_FFFF_FFFF_FFFF;
        RESET_N         = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #1;
            check($sformatf("post_reset%0d", k), 4'b0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
